// File: rtl/reg_enc_pkg.sv
// Shared constants for the register request encoder.
// Round-robin picking is enabled by defining ENC_ROUND_ROBIN_EN; the default build uses fixed priority.
package reg_enc_pkg;

    localparam int NREQ = 8;
    localparam int AW   = 3;

    localparam logic [AW-1:0] LAST_RST = 3'd7;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/reg_req_encoder8to3_rr_pick8.sv
// Combinational picker: finds the first set PEND bit starting just after LAST, wrapping modulo 8.
// With LAST held at 7 the search starts at 0, which gives lowest-index fixed priority.
module rr_pick8
    import reg_enc_pkg::*;
(
    input  logic [NREQ-1:0] pend,
    input  logic [AW-1:0]   last,
    output logic            hit,
    output logic [AW-1:0]   idx,
    output logic [NREQ-1:0] onehot
);

    logic [AW-1:0] cand;

    // Walk the rotated positions from farthest to nearest so the nearest set bit wins.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            cand = last + AW'(j) + AW'(1);
            if (pend[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
        if (hit) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_req_encoder8to3.sv
// Collects per-register request pulses into a sticky pending set and serializes them as 3-bit addresses
// over a VALID/RDY handshake. Define ENC_ROUND_ROBIN_EN for round-robin picking; otherwise lowest index wins.
module reg_req_encoder8to3
    import reg_enc_pkg::*;
(
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            EN,
    input  logic [NREQ-1:0] REQ,
    output logic [AW-1:0]   A,
    output logic            VALID,
    input  logic            RDY,
    output logic            DROP,
    output logic            BUSY
);

    logic [NREQ-1:0] pend_q, pend_d;
    logic [AW-1:0]   a_q, a_d;
    logic [0:0]      state_q, state_d;
    logic            drop_q, drop_d;

    logic [NREQ-1:0] new_req;
    logic [NREQ-1:0] clr;
    logic            load;
    logic            pick_hit;
    logic [AW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic [AW-1:0]   pick_last;

`ifdef ENC_ROUND_ROBIN_EN
    logic [AW-1:0]   last_q, last_d;

    always_comb begin
        last_d = load ? pick_idx : last_q;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            last_q <= LAST_RST;
        end else begin
            last_q <= last_d;
        end
    end

    assign pick_last = last_q;
`else
    assign pick_last = LAST_RST;
`endif

    rr_pick8 u_pick (
        .pend   (pend_q),
        .last   (pick_last),
        .hit    (pick_hit),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // A load happens whenever the slot is free or being drained this edge and something is pending.
    always_comb begin
        new_req = REQ & {NREQ{EN}};
        load    = pick_hit && ((state_q == ST_EMPTY) || RDY);
        clr     = load ? pick_onehot : '0;
        pend_d  = new_req | (pend_q & ~clr);
        drop_d  = |(new_req & pend_q & ~clr);
        a_d     = load ? pick_idx : a_q;
        state_d = state_q;
        if (load) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && RDY) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pend_q  <= '0;
            a_q     <= '0;
            state_q <= ST_EMPTY;
            drop_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            a_q     <= a_d;
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    assign A     = a_q;
    assign VALID = (state_q == ST_FULL);
    assign DROP  = drop_q;
    assign BUSY  = (|pend_q) | VALID;

endmodule

// File: tb/tb_reg_req_encoder8to3.sv
// Directed self-checking bench for reg_req_encoder8to3.
// Expected values are hand-computed; the fixed-priority and round-robin builds differ only where marked.
module tb_reg_req_encoder8to3;

   logic       Clock;
   logic       Resetn;
   logic       EN;
   logic [7:0] REQ;
   logic [2:0] A;
   logic       VALID;
   logic       RDY;
   logic       DROP;
   logic       BUSY;

   int checkCount;
   int failCount;

   reg_req_encoder8to3 dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .EN     (EN),
      .REQ    (REQ),
      .A      (A),
      .VALID  (VALID),
      .RDY    (RDY),
      .DROP   (DROP),
      .BUSY   (BUSY)
   );

   // Free-running 10 ns clock.
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Compare one observed value against its expected value and count it.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive inputs just after an edge, advance one clock, and leave time 1 ns past the next edge.
   task automatic applyStimulus(input logic en, input logic [7:0] req, input logic rdy);
      EN  = en;
      REQ = req;
      RDY = rdy;
      @(posedge Clock);
      #1;
   endtask

   // Pulse reset asynchronously and realign to 1 ns after a rising edge.
   task automatic doReset();
      EN     = 1'b1;
      REQ    = 8'h00;
      RDY    = 1'b1;
      #2;
      Resetn = 1'b0;
      #3;
      Resetn = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      Resetn     = 1'b0;
      EN         = 1'b1;
      REQ        = 8'hFF;
      RDY        = 1'b1;

      // Reset holds everything idle even with requests asserted.
      repeat (3) @(posedge Clock);
      #1;
      checkOutput("rst_valid", VALID, 0);
      checkOutput("rst_drop", DROP, 0);
      checkOutput("rst_busy", BUSY, 0);
      checkOutput("rst_a", A, 0);
      REQ = 8'h00;
      #2;
      Resetn = 1'b1;
      @(posedge Clock);
      #1;
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("post_rst_valid", VALID, 0);
      checkOutput("post_rst_busy", BUSY, 0);

      // Single request: two-cycle latency, one cycle of VALID.
      applyStimulus(1'b1, 8'h20, 1'b1);
      checkOutput("single_pend_valid", VALID, 0);
      checkOutput("single_pend_busy", BUSY, 1);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("single_valid", VALID, 1);
      checkOutput("single_a", A, 5);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("single_done_valid", VALID, 0);
      checkOutput("single_done_busy", BUSY, 0);

      // Burst of four requests from a fresh pointer drains back to back.
      doReset();
      applyStimulus(1'b1, 8'h93, 1'b1);
      checkOutput("burst_pend_valid", VALID, 0);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("burst_a0", A, 0);
      checkOutput("burst_v0", VALID, 1);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("burst_a1", A, 1);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("burst_a2", A, 4);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("burst_a3", A, 7);
      checkOutput("burst_v3", VALID, 1);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("burst_end_valid", VALID, 0);
      applyStimulus(1'b1, 8'h03, 1'b1);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("wrap_a0", A, 0);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("wrap_a1", A, 1);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("wrap_end_valid", VALID, 0);

      // Backpressure holds A stable until RDY rises.
      doReset();
      applyStimulus(1'b1, 8'h0C, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput("bp_first_a", A, 2);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'h00, 1'b0);
         checkOutput("bp_hold_a", A, 2);
         checkOutput("bp_hold_valid", VALID, 1);
      end
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("bp_next_a", A, 3);
      checkOutput("bp_next_valid", VALID, 1);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("bp_end_valid", VALID, 0);

      // Duplicate request on a pending bit pulses DROP once; EN low blocks new requests.
      doReset();
      applyStimulus(1'b1, 8'h01, 1'b0);
      applyStimulus(1'b1, 8'h40, 1'b0);
      checkOutput("ovf_first_drop", DROP, 0);
      checkOutput("ovf_held_a", A, 0);
      applyStimulus(1'b1, 8'h40, 1'b0);
      checkOutput("ovf_drop", DROP, 1);
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput("ovf_drop_clear", DROP, 0);
      applyStimulus(1'b0, 8'hFF, 1'b0);
      checkOutput("en_off_drop", DROP, 0);
      checkOutput("en_off_a", A, 0);
      checkOutput("en_off_busy", BUSY, 1);
      applyStimulus(1'b0, 8'hFF, 1'b1);
      checkOutput("ovf_deliver_a", A, 6);
      checkOutput("ovf_deliver_valid", VALID, 1);
      applyStimulus(1'b0, 8'hFF, 1'b1);
      checkOutput("ovf_end_valid", VALID, 0);
      checkOutput("ovf_end_busy", BUSY, 0);

      // Re-request on the bit being loaded: set wins; pick order shows the arbitration policy.
      doReset();
      applyStimulus(1'b1, 8'h81, 1'b1);
      applyStimulus(1'b1, 8'h01, 1'b1);
      checkOutput("prio_a0", A, 0);
      applyStimulus(1'b1, 8'h00, 1'b1);
`ifdef ENC_ROUND_ROBIN_EN
      checkOutput("prio_a1", A, 7);
`else
      checkOutput("prio_a1", A, 0);
`endif
      applyStimulus(1'b1, 8'h00, 1'b1);
`ifdef ENC_ROUND_ROBIN_EN
      checkOutput("prio_a2", A, 0);
`else
      checkOutput("prio_a2", A, 7);
`endif
      checkOutput("prio_v2", VALID, 1);
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput("prio_end_valid", VALID, 0);

      // Asynchronous reset mid-transfer drops the held address and pending set.
      applyStimulus(1'b1, 8'h18, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput("mid_valid", VALID, 1);
      #2;
      Resetn = 1'b0;
      #1;
      checkOutput("mid_rst_valid", VALID, 0);
      checkOutput("mid_rst_busy", BUSY, 0);
      Resetn = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
